// File: rtl/md_pkg.sv
// md_pkg: shared op codes, FSM state and op-class helpers
// for the multiply/divide unit.
package md_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_mul_class(input logic [3:0] op);
        return (op == OP_MULT)  || (op == OP_MULTU) ||
               (op == OP_MADD)  || (op == OP_MADDU) ||
               (op == OP_MSUB)  || (op == OP_MSUBU);
    endfunction

    function automatic logic is_div_class(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) ||
               (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/md_divider.sv
// md_divider: combinational signed/unsigned quotient and remainder,
// flagging the MIN/-1 overflow case and a zero divisor.
import md_pkg::*;

module md_divider #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_ovf,
    output logic             o_dz
);

    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_dvs;
    logic [WIDTH-1:0] w_uq;
    logic [WIDTH-1:0] w_ur;
    logic [WIDTH-1:0] w_min;

    assign w_min   = {1'b1, {(WIDTH-1){1'b0}}};
    assign w_neg_a = i_signed & i_a[WIDTH-1];
    assign w_neg_b = i_signed & i_b[WIDTH-1];
    assign w_mag_a = w_neg_a ? ('0 - i_a) : i_a;
    assign w_mag_b = w_neg_b ? ('0 - i_b) : i_b;

    assign o_dz  = (i_b == '0);
    assign o_ovf = i_signed & (i_a == w_min) & (i_b == '1);

    // Substitute a unit divisor so a zero divisor never reaches the divider.
    assign w_dvs = o_dz ? {{(WIDTH-1){1'b0}}, 1'b1} : w_mag_b;
    assign w_uq  = w_mag_a / w_dvs;
    assign w_ur  = w_mag_a % w_dvs;

    always_comb begin
        o_quo = (w_neg_a ^ w_neg_b) ? ('0 - w_uq) : w_uq;
        o_rem = w_neg_a ? ('0 - w_ur) : w_ur;
        if (o_ovf) begin
            o_quo = w_min;
            o_rem = '0;
        end
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning HI/LO, with
// accumulate ops, completion pulse and flush cancel.
import md_pkg::*;

module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cancel,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int W2   = 2 * WIDTH;

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_launch;
    logic             w_commit;
    logic             w_move;
    logic             w_sgn;
    logic [W2-1:0]    w_ext_a;
    logic [W2-1:0]    w_ext_b;
    logic [W2-1:0]    w_prod;
    logic [W2-1:0]    w_acc;
    logic [W2-1:0]    w_res;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic             w_ovf;
    logic             w_dz;

    assign w_sgn   = is_signed_op(r_op);
    assign w_ext_a = {{WIDTH{w_sgn & r_a[WIDTH-1]}}, r_a};
    assign w_ext_b = {{WIDTH{w_sgn & r_b[WIDTH-1]}}, r_b};
    // Truncated 2W x 2W product equals the signed/unsigned full product.
    assign w_prod  = w_ext_a * w_ext_b;
    assign w_acc   = {r_hi, r_lo};

    md_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_signed (w_sgn),
        .o_quo    (w_quo),
        .o_rem    (w_rem),
        .o_ovf    (w_ovf),
        .o_dz     (w_dz)
    );

    always_comb begin
        w_res = w_acc;
        unique case (1'b1)
            (r_op == OP_MULT),  (r_op == OP_MULTU): w_res = w_prod;
            (r_op == OP_MADD),  (r_op == OP_MADDU): w_res = w_acc + w_prod;
            (r_op == OP_MSUB),  (r_op == OP_MSUBU): w_res = w_acc - w_prod;
            is_div_class(r_op): w_res = w_dz ? w_acc : {w_rem, w_quo};
            default: w_res = w_acc;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_commit    = 1'b0;
        w_move      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start && !i_cancel) begin
                    if (is_mul_class(i_op) || is_div_class(i_op)) begin
                        w_launch    = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_move = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (i_cancel) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CW'(1)) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_commit;
            if (w_launch) begin
                r_op  <= i_op;
                r_a   <= i_a;
                r_b   <= i_b;
                r_cnt <= is_mul_class(i_op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (r_state == ST_RUN) begin
                r_cnt <= (i_cancel || w_commit) ? '0 : r_cnt - CW'(1);
            end
            if (w_commit) begin
                {r_hi, r_lo} <= w_res;
            end else if (w_move && i_op == OP_MTHI) begin
                r_hi <= i_a;
            end else if (w_move && i_op == OP_MTLO) begin
                r_lo <= i_a;
            end
        end
    end

    assign o_busy = (r_state == ST_RUN);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vectors with hand-computed HI/LO, latency,
// done-pulse, cancel, collision and reset checks.
import md_pkg::*;

module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    md_unit #(
        .WIDTH       (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_start  (start),
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .i_cancel (cancel),
        .o_busy   (busy),
        .o_done   (done),
        .o_hi     (hi),
        .o_lo     (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle start request; returns at the negedge after the edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic c);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        cancel = c;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        a      = 32'hDEAD_BEEF;
        b      = 32'hDEAD_BEEF;
    endtask

    task automatic run_op(input string tag, input logic [3:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input int n, input logic [31:0] ehi,
                          input logic [31:0] elo);
        int cyc;
        int dn;
        issue(o, x, y, 1'b0);
        cyc = 0;
        dn  = 0;
        while (busy && cyc < 200) begin
            if (done) dn++;
            cyc++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 64'(cyc), 64'(n));
        chk({tag, " early done"}, 64'(dn), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " hi"}, 64'(hi), 64'(ehi));
        chk({tag, " lo"}, 64'(lo), 64'(elo));
        @(negedge clk);
        chk({tag, " done 1cyc"}, 64'(done), 64'd0);
    endtask

    task automatic move(input string tag, input logic [3:0] o,
                        input logic [31:0] x);
        issue(o, x, 32'd0, 1'b0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int dn;
        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = '0;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hilo", {hi, lo}, 64'd0);

        run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
               32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", OP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10,
               32'd0, 32'h8000_0000);

        move("mthi", OP_MTHI, 32'h11);
        move("mtlo", OP_MTLO, 32'h22);
        chk("mt hilo", {hi, lo}, 64'h0000_0011_0000_0022);
        run_op("div0", OP_DIV, 32'd9, 32'd0, 10, 32'h11, 32'h22);

        move("mthi0", OP_MTHI, 32'd0);
        move("mtlo5", OP_MTLO, 32'd5);
        run_op("maddu", OP_MADDU, 32'hFFFF_FFFF, 32'd2, 5, 32'd2, 32'd3);
        run_op("msub", OP_MSUB, 32'd1, 32'd1, 5, 32'd2, 32'd2);
        run_op("madd", OP_MADD, 32'hFFFF_FFFF, 32'd3, 5, 32'd1, 32'hFFFF_FFFF);
        run_op("msubu", OP_MSUBU, 32'd2, 32'd3, 5, 32'd1, 32'hFFFF_FFF9);

        // Cancel a divu during its 4th busy cycle.
        move("mthi c", OP_MTHI, 32'h11);
        move("mtlo c", OP_MTLO, 32'h22);
        issue(OP_DIVU, 32'd7, 32'd2, 1'b0);
        repeat (3) @(negedge clk);
        chk("cancel pre busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel busy", 64'(busy), 64'd0);
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("cancel no done", 64'(dn), 64'd0);
        chk("cancel hilo", {hi, lo}, 64'h0000_0011_0000_0022);

        // Start while busy is ignored.
        issue(OP_MULT, 32'd3, 32'd4, 1'b0);
        @(negedge clk);
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        while (busy && dn < 50) begin
            dn++;
            @(negedge clk);
        end
        chk("busy start lat", 64'(dn), 64'd3);
        chk("busy start res", {hi, lo}, 64'd12);
        @(negedge clk);
        chk("busy start idle", 64'(busy), 64'd0);

        // Cancel and start together: nothing accepted.
        issue(OP_MULT, 32'd5, 32'd5, 1'b1);
        chk("cs busy", 64'(busy), 64'd0);
        issue(OP_MTHI, 32'h77, 32'd0, 1'b1);
        chk("cs mthi", {hi, lo}, 64'd12);

        // Undefined op is a no-op.
        issue(4'hF, 32'd5, 32'd5, 1'b0);
        chk("undef busy", 64'(busy), 64'd0);
        chk("undef hilo", {hi, lo}, 64'd12);

        // Reset mid-mult.
        issue(OP_MULT, 32'd6, 32'd7, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst mid busy", 64'(busy), 64'd0);
        chk("rst mid hilo", {hi, lo}, 64'd0);
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("rst mid done", 64'(dn), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
